// File: rtl/glyph_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : glyph_row_streamer
// Purpose  : Writable glyph table streaming one bitmap row per valid/ready beat.
//            Optional GLYPH_ROW_STREAMER_INVERT_EN adds per-request inversion.
// Revision : 1.0 - initial release
// ============================================================================
module glyph_row_streamer #(
    parameter  int GLYPH_W    = 8,
    parameter  int GLYPH_H    = 16,
    parameter  int CODE_W     = 7,
    parameter  int NUM_GLYPHS = 64,
    localparam int ROW_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
    input  logic               s,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [CODE_W-1:0]  wr_code,
    input  logic [ROW_W-1:0]   wr_row,
    input  logic [GLYPH_W-1:0] wr_data,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CODE_W-1:0]  req_code,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GLYPH_W-1:0] out_data,
    output logic [ROW_W-1:0]   out_row,
    output logic               out_last,
    output logic               busy
`ifdef GLYPH_ROW_STREAMER_INVERT_EN
    ,
    input  logic               req_inv
`endif
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_STREAM = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [GLYPH_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic [GLYPH_W-1:0] table_q [NUM_GLYPHS][GLYPH_H];

    logic [CODE_W-1:0]  w_rd_code;
    logic [ROW_W-1:0]   w_rd_row;
    logic [GLYPH_W-1:0] w_rd_data;
    logic [GLYPH_W-1:0] w_inv_mask;
    logic               w_beat_done;

    assign w_beat_done = valid_q && out_ready;

    // Full-width code/row compares: out-of-range writes and reads never match an entry.
    always_ff @(posedge s or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NUM_GLYPHS; g++) begin
                for (int r = 0; r < GLYPH_H; r++) begin
                    table_q[g][r] <= '0;
                end
            end
        end else begin
            for (int g = 0; g < NUM_GLYPHS; g++) begin
                for (int r = 0; r < GLYPH_H; r++) begin
                    if (wr_en && (wr_code == CODE_W'(g)) && (wr_row == ROW_W'(r))) begin
                        table_q[g][r] <= wr_data;
                    end
                end
            end
        end
    end

    assign w_rd_code = (state_q == c_IDLE) ? req_code : code_q;
    assign w_rd_row  = (state_q == c_IDLE) ? '0 : row_q + 1'b1;

    always_comb begin
        w_rd_data = '0;
        for (int g = 0; g < NUM_GLYPHS; g++) begin
            for (int r = 0; r < GLYPH_H; r++) begin
                if ((w_rd_code == CODE_W'(g)) && (w_rd_row == ROW_W'(r))) begin
                    w_rd_data = table_q[g][r];
                end
            end
        end
    end

`ifdef GLYPH_ROW_STREAMER_INVERT_EN
    logic inv_q, inv_d;

    assign inv_d      = ((state_q == c_IDLE) && req_valid) ? req_inv : inv_q;
    assign w_inv_mask = {GLYPH_W{(state_q == c_IDLE) ? req_inv : inv_q}};

    always_ff @(posedge s or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`else
    assign w_inv_mask = '0;
`endif

    always_ff @(posedge s or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (req_valid) state_d = c_STREAM;
            c_STREAM: if (w_beat_done && last_q) state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == c_IDLE);
        busy      = (state_q == c_STREAM);
    end

    always_comb begin
        code_d  = code_q;
        row_d   = row_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            c_IDLE: begin
                if (req_valid) begin
                    code_d  = req_code;
                    row_d   = '0;
                    data_d  = w_rd_data ^ w_inv_mask;
                    valid_d = 1'b1;
                    last_d  = (GLYPH_H == 1);
                end
            end
            c_STREAM: begin
                if (w_beat_done) begin
                    if (!last_q) begin
                        row_d  = row_q + 1'b1;
                        data_d = w_rd_data ^ w_inv_mask;
                        last_d = ((row_q + 1'b1) == ROW_W'(GLYPH_H - 1));
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge s or posedge rst) begin
        if (rst) begin
            code_q  <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            code_q  <= code_d;
            row_q   <= row_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_last  = last_q;

endmodule
`default_nettype wire

// File: doc/glyph_row_streamer.md
Name: glyph_row_streamer

Overview:
- Writable glyph table, parametrised in glyph width, height and glyph count, feeding the VGA text path.
- Accepts one character code per request and streams that glyph's bitmap rows, one row per beat, under valid/ready backpressure.
- Replaces the fixed 16-output, 8-bit, single-glyph lookup with a loadable table and a handshaked row stream.

Parameters:
- GLYPH_W, 8, pixels per glyph row (bits per beat)
- GLYPH_H, 16, rows per glyph (beats per request)
- CODE_W, 7, character code width
- NUM_GLYPHS, 64, table entries; valid codes are 0..NUM_GLYPHS-1
- ROW_W, derived localparam = clog2(GLYPH_H), not overridable

Ports:
- s  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- wr_en  input  1  table write strobe
- wr_code  input  CODE_W  glyph to write
- wr_row  input  ROW_W  row to write
- wr_data  input  GLYPH_W  row bitmap
- req_valid  input  1  request present
- req_ready  output  1  request accepted when valid&&ready
- req_code  input  CODE_W  requested character
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts beat
- out_data  output  GLYPH_W  current row bitmap, MSB = leftmost pixel
- out_row  output  ROW_W  index of current row
- out_last  output  1  high on row GLYPH_H-1
- busy  output  1  high while in STREAM

Behaviour:
- Clock is s; reset is asynchronous and active-high.
- Reset values: every table row = 0; state = IDLE; out_valid=0, out_data=0, out_row=0, out_last=0, busy=0; req_ready=1 once rst deasserts.
- Table storage is flops; all of it clears on rst (code 0 and every unwritten glyph read as all zeros).
- Writes are synchronous. If wr_en=1 and wr_code<NUM_GLYPHS: table[wr_code][wr_row] <= wr_data. Writes with wr_code>=NUM_GLYPHS, or wr_row>=GLYPH_H when GLYPH_H is not a power of two, are ignored.
- Writes are accepted in any state.
- FSM states: IDLE and STREAM.
- IDLE:
  - req_ready=1.
  - On req_valid at edge N: latch code; load out_data=table[code][0] and out_row=0; set out_valid=1; set out_last=(GLYPH_H==1); go to STREAM.
  - Latency from request handshake to first valid beat is one cycle.
- STREAM:
  - req_ready=0.
  - On out_valid&&out_ready with out_last=0: out_row+1, out_data=table[code][out_row+1], out_last=(out_row+1==GLYPH_H-1).
  - On out_valid&&out_ready with out_last=1: out_valid=0, out_last=0, out_data held, go to IDLE.
  - Result: at least one idle cycle between requests.
- Backpressure: while out_valid&&!out_ready, out_data, out_row and out_last hold stable.
- Read/write ordering: a row is sampled from the table at the edge it loads into out_data.
  - A same-edge write to that row is not seen; the old value is sent.
  - A write to a later row of the active glyph is seen when that row loads.
- Out-of-range request code (>=NUM_GLYPHS): accepted normally; streams GLYPH_H beats of all-zero data.
- rst mid-stream aborts the stream immediately, clears the table and returns to IDLE. No partial last beat is emitted.
- Throughput: one row per cycle under continuous out_ready. A full glyph takes GLYPH_H+1 cycles including the request cycle.

Optional Feature:
- Macro: GLYPH_ROW_STREAMER_INVERT_EN.
- Defined:
  - Extra input port req_inv (1 bit), latched with req_code on request handshake.
  - When the latched value is 1, every out_data beat of that request is the bitwise complement of the table row. This includes out-of-range codes, which then stream all ones.
  - Reset clears the latched value to 0.
- Undefined: no req_inv port; data always streams non-inverted.

Test Plan:
- Reset then request code 0 with out_ready=1 -> 16 beats of 0x00, out_row 0..15, out_last only on beat 15, req_ready low throughout and high again the cycle after the last beat.
- Write glyph 5 rows r=0..15 with data 0x10+r, request 5, out_ready toggling 1,0,1,0 -> beats 0x10..0x1F in order, each held unchanged while out_ready=0.
- Request 5; write table[5][3]=0xAA on the edge row 3 loads, then table[5][9]=0x55 while row 4 is out -> row 3 shows 0x13, row 9 shows 0x55.
- Request code 100 (>=NUM_GLYPHS=64) after writing wr_code=100 -> 16 beats of 0x00; the write had no effect.
- Assert rst at row 7 of a stream -> out_valid=0 and busy=0 the same cycle; after release, request 5 streams zeros.
- With GLYPH_ROW_STREAMER_INVERT_EN, request 5 with req_inv=1 -> beats 0xEF..0xE0; next request with req_inv=0 -> 0x10..0x1F.
